step_monitor: RTL

STEP_MONITOR -- requirements
Module: step_monitor

---
 rtl/step_monitor_pkg.sv | 24 ++
 rtl/step_monitor_if.sv | 27 ++
 rtl/step_monitor_axis.sv | 75 +++++++
 rtl/step_monitor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/step_monitor_pkg.sv
// Shared widths, FSM encoding and fault codes for the step monitor.
// Every file of the monitor imports from here.
package step_monitor_pkg;

  localparam int unsigned XY_LIMIT_DEF  = 11;
  localparam int unsigned Z_LIMIT_DEF   = 9;
  localparam int unsigned IVL_LIMIT_DEF = 26;
  localparam int unsigned WD_LIMIT_DEF  = 28;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERRUN   = 2'd1,
    FC_OVERSPEED = 2'd2,
    FC_TIMEOUT   = 2'd3
  } fault_code_e;

endpackage

// File: rtl/step_monitor_if.sv
// Step lines, move request and status bundle between a motion controller and the monitor.
interface step_monitor_if #(
  parameter int unsigned xy_limit  = step_monitor_pkg::XY_LIMIT_DEF,
  parameter int unsigned z_limit   = step_monitor_pkg::Z_LIMIT_DEF,
  parameter int unsigned ivl_limit = step_monitor_pkg::IVL_LIMIT_DEF
);
  logic                 stepx, stepy, stepz;
  logic                 start, clr;
  logic [xy_limit-1:0]  disx, disy;
  logic [z_limit-1:0]   disz;
  logic [ivl_limit-1:0] minx, miny, minz;
  logic [xy_limit+3:0]  cntx, cnty;
  logic [z_limit+3:0]   cntz;
  logic                 busy, done, fault;
  logic [1:0]           fault_code;
  logic [2:0]           fault_axis;

  modport master (
    output stepx, stepy, stepz, start, clr, disx, disy, disz, minx, miny, minz,
    input  cntx, cnty, cntz, busy, done, fault, fault_code, fault_axis
  );

  modport slave (
    input  stepx, stepy, stepz, start, clr, disx, disy, disz, minx, miny, minz,
    output cntx, cnty, cntz, busy, done, fault, fault_code, fault_axis
  );
endinterface

// File: rtl/step_monitor_axis.sv
// step_axis_mon: one axis of the monitor -- toggle edge detect, step count against
// target, and minimum edge-to-edge interval check.
module step_axis_mon #(
  parameter int unsigned cnt_w = step_monitor_pkg::XY_LIMIT_DEF + 4,
  parameter int unsigned ivl_w = step_monitor_pkg::IVL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             load_i,
  input  logic             upd_i,
  input  logic [cnt_w-1:0] tgt_i,
  input  logic [ivl_w-1:0] min_i,
  output logic             edge_o,
  output logic             complete_o,
  output logic             overrun_o,
  output logic             overspeed_o,
  output logic [cnt_w-1:0] cnt_o
);

  logic             step_q;
  logic             seen_q, seen_d;
  logic [cnt_w-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  logic [ivl_w-1:0] ivl_q, ivl_d, min_q, min_d;

  assign edge_o      = step_i ^ step_q;
  assign complete_o  = (cnt_q == tgt_q);
  assign overrun_o   = edge_o && complete_o;
  assign overspeed_o = edge_o && seen_q && (ivl_q < min_q);
  assign cnt_o       = cnt_q;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    ivl_d  = ivl_q;
    seen_d = seen_q;
    tgt_d  = tgt_q;
    min_d  = min_q;
    if (load_i) begin
      tgt_d  = tgt_i;
      min_d  = min_i;
      cnt_d  = '0;
      ivl_d  = '0;
      seen_d = 1'b0;
    end else if (upd_i) begin
      if (edge_o) begin
        if (!complete_o) cnt_d = cnt_q + cnt_w'(1);
        ivl_d  = ivl_w'(1);
        seen_d = 1'b1;
      end else if (ivl_q != '1) begin
        ivl_d = ivl_q + ivl_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples values from before this edge.
    if (rst) begin
      step_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
      tgt_q  <= '0;
      ivl_q  <= '0;
      min_q  <= '0;
    end else begin
      step_q <= step_i;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
      tgt_q  <= tgt_d;
      ivl_q  <= ivl_d;
      min_q  <= min_d;
    end
  end

endmodule

// File: rtl/step_monitor.sv
// Checks a commanded X/Y/Z move against toggle-encoded step lines: distance,
// minimum step spacing and a stall watchdog, reporting done or a coded fault.
module step_monitor import step_monitor_pkg::*; #(
  parameter int unsigned xy_limit  = XY_LIMIT_DEF,
  parameter int unsigned z_limit   = Z_LIMIT_DEF,
  parameter int unsigned ivl_limit = IVL_LIMIT_DEF,
  parameter int unsigned wd_limit  = WD_LIMIT_DEF
) (
  input logic          clk,
  input logic          rst,
  step_monitor_if.slave bus
);

  localparam int unsigned XY_CW = xy_limit + 4;
  localparam int unsigned Z_CW  = z_limit + 4;

  state_e              state_q, state_d;
  fault_code_e         fault_code_q, fault_code_d;
  logic [2:0]          fault_axis_q, fault_axis_d;
  logic [wd_limit-1:0] wd_q, wd_d;

  logic       in_track, load, upd, timeout, any_fault;
  logic [2:0] edge_v, complete_v, ovr_raw, osp_raw, overrun_v, overspeed_v, incomplete_v;

  assign in_track     = (state_q == ST_TRACK);
  assign load         = (state_q == ST_IDLE) && bus.start;
  assign overrun_v    = ovr_raw & {3{in_track}};
  assign overspeed_v  = osp_raw & {3{in_track}};
  assign incomplete_v = ~complete_v;
  assign timeout      = in_track && (&wd_q) && (|incomplete_v);
  assign any_fault    = (|overrun_v) || (|overspeed_v) || timeout;
  // A faulting cycle freezes counts and intervals as they were before it.
  assign upd          = in_track && !any_fault;

  step_axis_mon #(.cnt_w(XY_CW), .ivl_w(ivl_limit)) u_axis_x (
    .clk, .rst, .step_i(bus.stepx), .load_i(load), .upd_i(upd),
    .tgt_i({bus.disx, 4'b0000}), .min_i(bus.minx),
    .edge_o(edge_v[2]), .complete_o(complete_v[2]), .overrun_o(ovr_raw[2]),
    .overspeed_o(osp_raw[2]), .cnt_o(bus.cntx)
  );

  step_axis_mon #(.cnt_w(XY_CW), .ivl_w(ivl_limit)) u_axis_y (
    .clk, .rst, .step_i(bus.stepy), .load_i(load), .upd_i(upd),
    .tgt_i({bus.disy, 4'b0000}), .min_i(bus.miny),
    .edge_o(edge_v[1]), .complete_o(complete_v[1]), .overrun_o(ovr_raw[1]),
    .overspeed_o(osp_raw[1]), .cnt_o(bus.cnty)
  );

  step_axis_mon #(.cnt_w(Z_CW), .ivl_w(ivl_limit)) u_axis_z (
    .clk, .rst, .step_i(bus.stepz), .load_i(load), .upd_i(upd),
    .tgt_i({bus.disz, 4'b0000}), .min_i(bus.minz),
    .edge_o(edge_v[0]), .complete_o(complete_v[0]), .overrun_o(ovr_raw[0]),
    .overspeed_o(osp_raw[0]), .cnt_o(bus.cntz)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_TRACK;
      ST_TRACK: begin
        if (any_fault)        state_d = ST_FAULT;
        else if (&complete_v) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (bus.clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (state_q == ST_TRACK);
    bus.done       = (state_q == ST_DONE);
    bus.fault      = (state_q == ST_FAULT);
    bus.fault_code = fault_code_q;
    bus.fault_axis = fault_axis_q;
  end

  // Fault report: overrun beats overspeed beats timeout; only the winning type's axes are flagged.
  always_comb begin
    fault_code_d = fault_code_q;
    fault_axis_d = fault_axis_q;
    if (in_track) begin
      if (|overrun_v) begin
        fault_code_d = FC_OVERRUN;
        fault_axis_d = overrun_v;
      end else if (|overspeed_v) begin
        fault_code_d = FC_OVERSPEED;
        fault_axis_d = overspeed_v;
      end else if (timeout) begin
        fault_code_d = FC_TIMEOUT;
        fault_axis_d = incomplete_v;
      end
    end else if ((state_q == ST_FAULT) && bus.clr) begin
      fault_code_d = FC_NONE;
      fault_axis_d = 3'b000;
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (load) begin
      wd_d = '0;
    end else if (in_track) begin
      if (|edge_v)      wd_d = '0;
      else if (!(&wd_q)) wd_d = wd_q + wd_limit'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_code_q <= FC_NONE;
      fault_axis_q <= 3'b000;
      wd_q         <= '0;
    end else begin
      fault_code_q <= fault_code_d;
      fault_axis_q <= fault_axis_d;
      wd_q         <= wd_d;
    end
  end

endmodule
